// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the memory stage and the data cache port.
// One op in flight: issue with valid/ready, await response, return the extended load result.
module lsu_ctrl #(
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              kill,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              busy,
  output logic              dcache_req_valid,
  input  logic              dcache_req_ready,
  output logic [AWIDTH-1:0] dcache_req_addr,
  output logic [3:0]        dcache_req_we,
  output logic [31:0]       dcache_req_wdata,
  input  logic              dcache_resp_valid,
  input  logic [31:0]       dcache_resp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t state, state_nxt;
  logic   accept, complete;

  logic              is_store_p1;
  logic [2:0]        funct3_p1;
  logic [1:0]        off_p1;
  logic [AWIDTH-1:0] addr_p1;
  logic [3:0]        we_p1;
  logic [31:0]       wdata_p1;
  logic              vld_p2;
  logic [31:0]       resp_data_p2;

  function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] o);
    logic [3:0] we;
    case (f3)
      3'b000: we = 4'b0001 << o;
      3'b001: begin
        case (o)
          2'd0:    we = 4'b0011;
          2'd1:    we = 4'b0110;
          default: we = 4'b1100;
        endcase
      end
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [1:0] o,
                                             input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = (o == 2'd1) ? {8'h00, d[15:0], 8'h00} : {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[{o, 3'b000} +: 8];
    case (o)
      2'd0:    h = w[15:0];
      2'd1:    h = w[23:8];
      default: h = w[31:16];
    endcase
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    dcache_req_valid = 1'b0;
    accept           = 1'b0;
    complete         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !kill;
        if (req_valid && !kill) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        dcache_req_valid = 1'b1;
        if (dcache_req_ready) state_nxt = kill ? DRAIN : WAIT;
        else if (kill)        state_nxt = IDLE;
      end
      WAIT: begin
        if (dcache_resp_valid) begin
          complete  = !kill;
          state_nxt = IDLE;
        end else if (kill) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcache_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p1: op captured at accept, held stable for the cache request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_store_p1 <= 1'b0;
      funct3_p1   <= 3'b0;
      off_p1      <= 2'b0;
      addr_p1     <= '0;
      we_p1       <= 4'b0;
      wdata_p1    <= 32'h0;
    end else if (accept) begin
      is_store_p1 <= req_is_store;
      funct3_p1   <= req_funct3;
      off_p1      <= req_addr[1:0];
      addr_p1     <= {req_addr[AWIDTH-1:2], 2'b00};
      we_p1       <= req_is_store ? store_we(req_funct3, req_addr[1:0]) : 4'b0;
      wdata_p1    <= req_is_store ? store_data(req_funct3, req_addr[1:0], req_wdata) : 32'h0;
    end
  end

  // p2: registered completion result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2       <= 1'b0;
      resp_data_p2 <= 32'h0;
    end else begin
      vld_p2 <= complete;
      if (complete)
        resp_data_p2 <= is_store_p1 ? 32'h0 : load_ext(funct3_p1, off_p1, dcache_resp_data);
    end
  end

  assign busy             = (state != IDLE);
  assign resp_valid       = vld_p2;
  assign resp_data        = resp_data_p2;
  assign dcache_req_addr  = addr_p1;
  assign dcache_req_we    = we_p1;
  assign dcache_req_wdata = wdata_p1;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single ops plus handshake/kill/reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store, kill;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, busy;
  logic [31:0] resp_data;
  logic        dcache_req_valid, dcache_req_ready;
  logic [31:0] dcache_req_addr;
  logic [3:0]  dcache_req_we;
  logic [31:0] dcache_req_wdata;
  logic        dcache_resp_valid;
  logic [31:0] dcache_resp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.AWIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .kill(kill),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_addr(dcache_req_addr), .dcache_req_we(dcache_req_we),
    .dcache_req_wdata(dcache_req_wdata), .dcache_resp_valid(dcache_resp_valid),
    .dcache_resp_data(dcache_resp_data)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_rsp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_is_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    kill = 0; dcache_req_ready = 0; dcache_resp_valid = 0; dcache_resp_data = 0;
  endtask

  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    present(v.st, v.f3, v.addr, v.wd);
    #2 chk({s, ".req_ready"}, 32'(req_ready), 1);
    cyc();
    req_valid = 0;
    dcache_req_ready = 1;
    #2;
    chk({s, ".dc_valid"}, 32'(dcache_req_valid), 1);
    chk({s, ".dc_addr"}, dcache_req_addr, v.addr & 32'hFFFF_FFFC);
    chk({s, ".dc_we"}, 32'(dcache_req_we), 32'(v.exp_we));
    chk({s, ".dc_wdata"}, dcache_req_wdata, v.exp_wd);
    cyc();
    dcache_req_ready = 0;
    dcache_resp_valid = 1;
    dcache_resp_data = v.rd;
    #2;
    chk({s, ".wait_busy"}, 32'(busy), 1);
    chk({s, ".wait_noresp"}, 32'(resp_valid), 0);
    cyc();
    dcache_resp_valid = 0;
    dcache_resp_data = 32'h0;
    #2;
    chk({s, ".resp_valid"}, 32'(resp_valid), 1);
    chk({s, ".resp_data"}, resp_data, v.exp_rsp);
    chk({s, ".ready_back"}, 32'(req_ready), 1);
    cyc();
    #2 chk({s, ".resp_pulse"}, 32'(resp_valid), 0);
  endtask

  initial begin
    vecs[0]  = '{0, 3'b000, 32'h0000_1103, 32'h0,         32'h80FF_1234, 4'b0000, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{0, 3'b101, 32'h0000_1101, 32'h0,         32'h12A5_5A34, 4'b0000, 32'h0,         32'h0000_A55A};
    vecs[2]  = '{0, 3'b001, 32'h0000_1101, 32'h0,         32'h12A5_5A34, 4'b0000, 32'h0,         32'hFFFF_A55A};
    vecs[3]  = '{0, 3'b100, 32'h0000_1102, 32'h0,         32'h12A5_5A34, 4'b0000, 32'h0,         32'h0000_00A5};
    vecs[4]  = '{0, 3'b010, 32'h0000_1103, 32'h0,         32'hDEAD_BEEF, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    vecs[5]  = '{0, 3'b001, 32'h0000_2100, 32'h0,         32'h0000_8001, 4'b0000, 32'h0,         32'hFFFF_8001};
    vecs[6]  = '{0, 3'b001, 32'h0000_2103, 32'h0,         32'h7FFF_0000, 4'b0000, 32'h0,         32'h0000_7FFF};
    vecs[7]  = '{1, 3'b001, 32'h0000_3102, 32'h0000_BEEF, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{1, 3'b000, 32'h0000_3101, 32'h1234_56AB, 32'hFFFF_FFFF, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[9]  = '{1, 3'b000, 32'h0000_3103, 32'h0000_00C3, 32'hFFFF_FFFF, 4'b1000, 32'hC3C3_C3C3, 32'h0};
    vecs[10] = '{1, 3'b001, 32'h0000_3100, 32'hFFFF_1234, 32'hFFFF_FFFF, 4'b0011, 32'h1234_1234, 32'h0};
    vecs[11] = '{1, 3'b010, 32'h0000_3102, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[12] = '{0, 3'b000, 32'h0000_4100, 32'h0,         32'h1111_117F, 4'b0000, 32'h0,         32'h0000_007F};

    idle_inputs();
    reset = 1;
    #2;
    chk("rst.req_ready", 32'(req_ready), 1);
    chk("rst.dc_valid", 32'(dcache_req_valid), 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.dc_we", 32'(dcache_req_we), 0);
    chk("rst.dc_addr", dcache_req_addr, 0);
    cyc(); cyc();
    reset = 0;
    cyc();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // backpressure: three cycles of ready low, handshake on the fourth
    present(1, 3'b010, 32'h0000_2004, 32'h1122_3344);
    cyc();
    for (int k = 0; k < 3; k++) begin
      req_valid = (k == 0) ? 1'b0 : 1'b1;
      #2;
      chk("bp.dc_valid", 32'(dcache_req_valid), 1);
      chk("bp.dc_addr", dcache_req_addr, 32'h0000_2004);
      chk("bp.dc_we", 32'(dcache_req_we), 32'hF);
      chk("bp.dc_wdata", dcache_req_wdata, 32'h1122_3344);
      chk("bp.req_ready", 32'(req_ready), 0);
      cyc();
    end
    req_valid = 0;
    dcache_req_ready = 1;
    #2 chk("bp.dc_valid4", 32'(dcache_req_valid), 1);
    cyc();
    dcache_req_ready = 0;
    #2 chk("bp.dc_valid_drop", 32'(dcache_req_valid), 0);
    dcache_resp_valid = 1;
    cyc();
    dcache_resp_valid = 0;
    #2;
    chk("bp.resp_valid", 32'(resp_valid), 1);
    chk("bp.resp_data", resp_data, 32'h0);
    cyc();

    // kill in WAIT, response two cycles later, next request accepted as busy drops
    present(0, 3'b010, 32'h0000_5000, 32'h0);
    cyc();
    req_valid = 0; dcache_req_ready = 1;
    cyc();
    dcache_req_ready = 0; kill = 1;
    cyc();
    kill = 0;
    #2;
    chk("kw.busy_drain", 32'(busy), 1);
    chk("kw.req_ready", 32'(req_ready), 0);
    cyc();
    dcache_resp_valid = 1; dcache_resp_data = 32'hAAAA_5555;
    #2 chk("kw.busy_resp", 32'(busy), 1);
    cyc();
    dcache_resp_valid = 0;
    present(0, 3'b010, 32'h0000_6000, 32'h0);
    #2;
    chk("kw.no_resp", 32'(resp_valid), 0);
    chk("kw.busy_low", 32'(busy), 0);
    chk("kw.req_ready", 32'(req_ready), 1);
    cyc();
    req_valid = 0;
    #2;
    chk("kw.next_issue", 32'(dcache_req_valid), 1);
    chk("kw.next_addr", dcache_req_addr, 32'h0000_6000);
    dcache_req_ready = 1;
    cyc();
    dcache_req_ready = 0; dcache_resp_valid = 1; dcache_resp_data = 32'h0BAD_F00D;
    cyc();
    dcache_resp_valid = 0;
    #2;
    chk("kw.next_resp_valid", 32'(resp_valid), 1);
    chk("kw.next_resp_data", resp_data, 32'h0BAD_F00D);
    cyc();

    // kill in ISSUE without handshake, and kill blocks acceptance in IDLE
    present(0, 3'b010, 32'h0000_7000, 32'h0);
    cyc();
    req_valid = 0; kill = 1;
    cyc();
    #2;
    chk("ki.dc_valid", 32'(dcache_req_valid), 0);
    chk("ki.busy", 32'(busy), 0);
    chk("ki.ready_kill", 32'(req_ready), 0);
    req_valid = 1;
    cyc();
    req_valid = 0; kill = 0;
    #2 chk("ki.no_accept", 32'(busy), 0);
    cyc();

    // kill together with handshake goes to DRAIN; drained response is discarded
    present(0, 3'b010, 32'h0000_7100, 32'h0);
    cyc();
    req_valid = 0; dcache_req_ready = 1; kill = 1;
    cyc();
    dcache_req_ready = 0; kill = 0;
    #2 chk("kh.busy", 32'(busy), 1);
    dcache_resp_valid = 1;
    cyc();
    dcache_resp_valid = 0;
    #2;
    chk("kh.no_resp", 32'(resp_valid), 0);
    chk("kh.idle", 32'(busy), 0);
    cyc();

    // kill together with response in WAIT
    present(0, 3'b010, 32'h0000_7200, 32'h0);
    cyc();
    req_valid = 0; dcache_req_ready = 1;
    cyc();
    dcache_req_ready = 0; dcache_resp_valid = 1; kill = 1;
    cyc();
    dcache_resp_valid = 0; kill = 0;
    #2;
    chk("kr.no_resp", 32'(resp_valid), 0);
    chk("kr.idle", 32'(busy), 0);
    cyc();

    // asynchronous reset while in WAIT, then a stale response
    present(0, 3'b010, 32'h0000_8000, 32'h0);
    cyc();
    req_valid = 0; dcache_req_ready = 1;
    cyc();
    dcache_req_ready = 0;
    #2 chk("rw.busy_pre", 32'(busy), 1);
    reset = 1;
    #1;
    chk("rw.dc_valid", 32'(dcache_req_valid), 0);
    chk("rw.req_ready", 32'(req_ready), 1);
    chk("rw.resp_valid", 32'(resp_valid), 0);
    chk("rw.busy", 32'(busy), 0);
    cyc();
    reset = 0;
    dcache_resp_valid = 1; dcache_resp_data = 32'h1234_5678;
    cyc();
    dcache_resp_valid = 0;
    #2;
    chk("rw.stale_resp", 32'(resp_valid), 0);
    chk("rw.stale_busy", 32'(busy), 0);
    cyc();
    #2 chk("rw.stale_resp2", 32'(resp_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
